hl_west_io_ctrl: RTL

- Control stage directly upstream of the 4-slice west IO pad wrapper.
- Drives every per-pad control input of the wrapper (dq, drv0-2, enabq, enq, pd, ppen, prg_slew, puq, pwrup_pull_en, pwrupzhl) from a small register file.
- Synchronises the wrapper's outi returns and records sticky rising-edge status.
- Runs a power-up sequence that holds the pads high-Z until the counter expires.
- Register file is accessed by the SoC through a valid/ready request port with one-cycle response.

---
 rtl/hl_west_io_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/hl_west_io_ctrl.sv
// Control stage for the 4-slice west IO pad wrapper.
// Holds a small register file that drives every per-pad control. It also synchronises
// the pad receiver returns and latches sticky rising-edge status.
// A power-up sequencer keeps the pads high-Z until its counter expires.
module hl_west_io_ctrl #(
    parameter int unsigned PWRUP_CYCLES = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clock,
    input  logic       reset,
    // SoC register port
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    output logic [7:0] resp_rdata,
    // Status
    output logic       irq,
    output logic       pwrup_done,
    // Pad wrapper controls, bit i drives slice i
    output logic [3:0] pad_dq,
    output logic [3:0] pad_drv0,
    output logic [3:0] pad_drv1,
    output logic [3:0] pad_drv2,
    output logic [3:0] pad_enabq,
    output logic [3:0] pad_enq,
    output logic [3:0] pad_pd,
    output logic [3:0] pad_ppen,
    output logic [3:0] pad_prg_slew,
    output logic [3:0] pad_puq,
    output logic [3:0] pad_pwrup_pull_en,
    output logic [3:0] pad_pwrupzhl,
    // Pad receiver outputs, asynchronous to clock
    input  logic [3:0] pad_outi
);

    // Register addresses
    localparam logic [2:0] ADDR_OUT  = 3'd0;
    localparam logic [2:0] ADDR_OE   = 3'd1;
    localparam logic [2:0] ADDR_IN   = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;

    // CFG reset value: drv=001, ppen=1, ie=1
    localparam logic [7:0] CFG_RST = 8'hC1;

    // Last counter value of the power-up window
    localparam logic [7:0] PWRUP_LAST = 8'(PWRUP_CYCLES - 1);

    typedef enum logic [0:0] {
        StPwrup,
        StRun
    } state_t;

    // Power-up sequencer state
    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_pwrup_done;
    logic       r_req_ready;

    // Register file
    logic [3:0] r_out;
    logic [3:0] r_oe;
    logic [3:0] r_edge;
    logic [7:0] r_cfg [4];

    // Input synchroniser and previous-sample for edge detection
    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] r_in_prev;

    // Response path
    logic       r_resp_valid;
    logic [7:0] r_resp_rdata;

    // Combinational helpers
    logic       w_accept;
    logic       w_wr;
    logic [3:0] w_in;
    logic [3:0] w_ie;
    logic [3:0] w_rise;
    logic [3:0] w_w1c;
    logic [7:0] w_rd_data;

    assign w_accept = req_valid & r_req_ready;
    assign w_wr     = w_accept & req_write;
    assign w_in     = r_sync[SYNC_STAGES-1];

    // Gather the per-slice input-enable bits
    always_comb begin
        w_ie = '0;
        for (int i = 0; i < 4; i++) begin
            w_ie[i] = r_cfg[i][7];
        end
    end

    // A rising edge only counts on slices whose receiver is enabled
    assign w_rise = w_in & ~r_in_prev & w_ie;
    assign w_w1c  = (w_wr && (req_addr == ADDR_EDGE)) ? req_wdata[3:0] : 4'h0;

    // Power-up sequencer: count out the high-Z window, then run until reset
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StPwrup;
            r_cnt        <= 8'h00;
            r_pwrup_done <= 1'b0;
            r_req_ready  <= 1'b0;
        end else begin
            unique case (r_state)
                StPwrup: begin
                    r_cnt <= r_cnt + 8'h01;
                    if (r_cnt == PWRUP_LAST) begin
                        r_state      <= StRun;
                        r_pwrup_done <= 1'b1;
                        r_req_ready  <= 1'b1;
                    end
                end
                StRun: begin
                    r_pwrup_done <= 1'b1;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_state <= StPwrup;
                end
            endcase
        end
    end

    // Writable control registers; IN is read-only and EDGE is handled separately
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out <= 4'h0;
            r_oe  <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                r_cfg[i] <= CFG_RST;
            end
        end else if (w_wr) begin
            if (req_addr == ADDR_OUT) begin
                r_out <= req_wdata[3:0];
            end
            if (req_addr == ADDR_OE) begin
                r_oe <= req_wdata[3:0];
            end
            if (req_addr[2]) begin
                r_cfg[req_addr[1:0]] <= req_wdata;
            end
        end
    end

    // Sticky edge status; a new edge beats a same-cycle write-1-to-clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_edge <= 4'h0;
        end else begin
            r_edge <= (r_edge & ~w_w1c) | w_rise;
        end
    end

    // Multi-flop synchroniser for the asynchronous pad returns
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= 4'h0;
            end
            r_in_prev <= 4'h0;
        end else begin
            r_sync[0] <= pad_outi;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_in_prev <= w_in;
        end
    end

    // Read mux; value is captured at acceptance, before that edge's write lands
    always_comb begin
        w_rd_data = 8'h00;
        case (req_addr)
            ADDR_OUT:  w_rd_data = {4'h0, r_out};
            ADDR_OE:   w_rd_data = {4'h0, r_oe};
            ADDR_IN:   w_rd_data = {4'h0, w_in};
            ADDR_EDGE: w_rd_data = {4'h0, r_edge};
            default:   w_rd_data = r_cfg[req_addr[1:0]];
        endcase
    end

    // One-cycle response for every accepted request; writes return zero
    always_ff @(posedge clock) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 8'h00;
        end else begin
            r_resp_valid <= w_accept;
            r_resp_rdata <= (w_accept && !req_write) ? w_rd_data : 8'h00;
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign pwrup_done = r_pwrup_done;
    assign irq        = |r_edge;

    // Pad controls are decoded purely from flops, never from the request inputs
    always_comb begin
        pad_dq            = ~r_out;
        pad_enq           = ~(r_oe & {4{r_pwrup_done}});
        pad_pwrupzhl      = {4{~r_pwrup_done}};
        pad_pwrup_pull_en = {4{~r_pwrup_done}};
        pad_drv0          = '0;
        pad_drv1          = '0;
        pad_drv2          = '0;
        pad_prg_slew      = '0;
        pad_puq           = '0;
        pad_pd            = '0;
        pad_ppen          = '0;
        pad_enabq         = '0;
        for (int i = 0; i < 4; i++) begin
            pad_drv0[i]     = r_cfg[i][0];
            pad_drv1[i]     = r_cfg[i][1];
            pad_drv2[i]     = r_cfg[i][2];
            pad_prg_slew[i] = r_cfg[i][3];
            pad_puq[i]      = ~r_cfg[i][4];
            pad_pd[i]       = r_cfg[i][5];
            pad_ppen[i]     = r_cfg[i][6];
            pad_enabq[i]    = ~r_cfg[i][7];
        end
    end

endmodule
